// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU definitions: data/address widths, fetch FSM states and the reset PC.
// Pure declarations with no logic, so there is no latency and no flow control here.
package CPU_package;

    localparam int DATA_WIDTH    = 16;
    localparam int ADDRESS_WIDTH = 12;

    localparam logic [ADDRESS_WIDTH-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter register: load has priority over increment, and the increment wraps at the top of memory.
// Latency is one cycle and there is no backpressure; the owner decides when to load or step.
module program_counter
    import CPU_package::*;
#(
    parameter int                   AW        = ADDRESS_WIDTH,
    parameter logic [AW-1:0]        RESET_VAL = RESET_PC
) (
    input  logic          iclk,
    input  logic          irst_n,
    input  logic          i_load,
    input  logic [AW-1:0] i_load_addr,
    input  logic          i_inc,
    output logic [AW-1:0] o_pc
);

    logic [AW-1:0] r_pc;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_pc <= RESET_VAL;
        end else if (i_load) begin
            r_pc <= i_load_addr;
        end else if (i_inc) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: it owns the PC, reads program memory over req/ack and strobes each word into the IR.
// All outputs are registered, and the word appears one edge after mem_ack. A held word blocks the next fetch until next or jump.
module instruction_fetch_unit
    import CPU_package::*;
#(
    parameter int                         DATA_WIDTH    = CPU_package::DATA_WIDTH,
    parameter int                         ADDRESS_WIDTH = CPU_package::ADDRESS_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = CPU_package::RESET_PC
) (
    input  logic                     iclk,
    input  logic                     irst_n,
    input  logic                     run,
    input  logic                     next,
    input  logic                     jump,
    input  logic [ADDRESS_WIDTH-1:0] jump_addr,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ack,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    insin,
    output logic                     loadIR,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic                     ins_valid
);

    fetch_state_t               r_state,     w_state_nxt;
    logic                       r_mem_req,   w_req_nxt;
    logic [ADDRESS_WIDTH-1:0]   r_mem_addr,  w_addr_nxt;
    logic [DATA_WIDTH-1:0]      r_insin,     w_ins_nxt;
    logic                       r_loadir,    w_ld_nxt;
    logic                       r_ins_valid, w_valid_nxt;
    logic                       r_flush,     w_flush_nxt;
    logic [ADDRESS_WIDTH-1:0]   r_target,    w_target_nxt;

    logic                       w_pc_load;
    logic [ADDRESS_WIDTH-1:0]   w_pc_load_addr;
    logic                       w_pc_inc;
    logic [ADDRESS_WIDTH-1:0]   w_pc;

    // A jump arriving in the same cycle as the ack must still kill that word.
    logic                       w_flush_eff;
    logic [ADDRESS_WIDTH-1:0]   w_target_eff;

    assign w_flush_eff  = r_flush | jump;
    assign w_target_eff = jump ? jump_addr : r_target;

    program_counter #(
        .AW        (ADDRESS_WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .iclk        (iclk),
        .irst_n      (irst_n),
        .i_load      (w_pc_load),
        .i_load_addr (w_pc_load_addr),
        .i_inc       (w_pc_inc),
        .o_pc        (w_pc)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_mem_req;
        w_addr_nxt     = r_mem_addr;
        w_ins_nxt      = r_insin;
        w_ld_nxt       = 1'b0;
        w_valid_nxt    = r_ins_valid;
        w_flush_nxt    = r_flush;
        w_target_nxt   = r_target;
        w_pc_load      = 1'b0;
        w_pc_load_addr = jump_addr;
        w_pc_inc       = 1'b0;

        case (r_state)
            IDLE: begin
                w_pc_load = jump;
                if (run) begin
                    w_state_nxt = FETCH;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = jump ? jump_addr : w_pc;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    if (w_flush_eff) begin
                        w_pc_load      = 1'b1;
                        w_pc_load_addr = w_target_eff;
                        w_flush_nxt    = 1'b0;
                        if (run) begin
                            w_addr_nxt = w_target_eff;
                        end else begin
                            w_state_nxt = IDLE;
                            w_req_nxt   = 1'b0;
                        end
                    end else begin
                        w_ins_nxt   = mem_rdata;
                        w_ld_nxt    = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_pc_inc    = 1'b1;
                        w_req_nxt   = 1'b0;
                        w_state_nxt = HOLD;
                    end
                end else if (jump) begin
                    w_flush_nxt  = 1'b1;
                    w_target_nxt = jump_addr;
                end
            end
            HOLD: begin
                if (jump || next) begin
                    w_pc_load   = jump;
                    w_valid_nxt = 1'b0;
                    if (run) begin
                        w_state_nxt = FETCH;
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = jump ? jump_addr : w_pc;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= RESET_PC;
            r_insin     <= '0;
            r_loadir    <= 1'b0;
            r_ins_valid <= 1'b0;
            r_flush     <= 1'b0;
            r_target    <= RESET_PC;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_req_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_insin     <= w_ins_nxt;
            r_loadir    <= w_ld_nxt;
            r_ins_valid <= w_valid_nxt;
            r_flush     <= w_flush_nxt;
            r_target    <= w_target_nxt;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign insin     = r_insin;
    assign loadIR    = r_loadir;
    assign pc        = w_pc;
    assign ins_valid = r_ins_valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a behavioural fetch model checked every cycle, plus directed literal checks.
module tb_instruction_fetch_unit;
    import CPU_package::*;

    localparam int DW = 16;
    localparam int AW = 12;

    logic          iclk = 1'b0;
    logic          irst_n;
    logic          run;
    logic          next;
    logic          jump;
    logic [AW-1:0] jump_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack   = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] insin;
    logic          loadIR;
    logic [AW-1:0] pc;
    logic          ins_valid;

    instruction_fetch_unit dut (
        .iclk      (iclk),
        .irst_n    (irst_n),
        .run       (run),
        .next      (next),
        .jump      (jump),
        .jump_addr (jump_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .insin     (insin),
        .loadIR    (loadIR),
        .pc        (pc),
        .ins_valid (ins_valid)
    );

    always #5 iclk = ~iclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Program memory: acks mem_wait+1 edges after a request is first seen.
    logic [DW-1:0] mem [0:4095];
    int  mem_wait  = 0;
    int  mem_cnt   = 0;
    bit  mem_en    = 1'b1;
    bit  force_ack = 1'b0;

    always @(negedge iclk) begin
        if (!mem_en) begin
            mem_ack   = force_ack;
            mem_rdata = 16'hDEAD;
        end else if (!mem_req) begin
            mem_cnt = 0;
            mem_ack = 1'b0;
        end else begin
            if (mem_ack) mem_cnt = 0;
            mem_ack   = (mem_cnt >= mem_wait);
            mem_rdata = mem[mem_addr];
            mem_cnt++;
        end
    end

    // Reference model: tracks the visible outputs from the fetch rules directly.
    int m_pc, m_addr, m_ins, m_tgt;
    bit m_req, m_ld, m_valid, m_flush;

    always @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            m_pc = 0; m_addr = 0; m_ins = 0; m_tgt = 0;
            m_req = 0; m_ld = 0; m_valid = 0; m_flush = 0;
        end else begin
            m_ld = 0;
            if (m_req) begin
                if (jump) begin
                    m_flush = 1;
                    m_tgt   = int'(jump_addr);
                end
                if (mem_ack) begin
                    if (m_flush) begin
                        m_pc    = m_tgt;
                        m_flush = 0;
                        if (run) m_addr = m_pc;
                        else     m_req  = 0;
                    end else begin
                        m_ins   = int'(mem_rdata);
                        m_ld    = 1;
                        m_valid = 1;
                        m_pc    = (m_pc + 1) % 4096;
                        m_req   = 0;
                    end
                end
            end else if (m_valid) begin
                if (jump || next) begin
                    if (jump) m_pc = int'(jump_addr);
                    m_valid = 0;
                    if (run) begin
                        m_req  = 1;
                        m_addr = m_pc;
                    end
                end
            end else begin
                if (jump) m_pc = int'(jump_addr);
                if (run) begin
                    m_req  = 1;
                    m_addr = m_pc;
                end
            end
        end
    end

    bit prev_ld  = 1'b0;
    int ld_count = 0;

    always @(posedge iclk) begin
        #1;
        if (irst_n) begin
            check("model_pc",        32'(pc),        32'(m_pc));
            check("model_mem_req",   32'(mem_req),   32'(m_req));
            check("model_mem_addr",  32'(mem_addr),  32'(m_addr));
            check("model_insin",     32'(insin),     32'(m_ins));
            check("model_loadIR",    32'(loadIR),    32'(m_ld));
            check("model_ins_valid", 32'(ins_valid), 32'(m_valid));
            check("loadIR_back_to_back", 32'(loadIR && prev_ld), 32'(0));
            prev_ld = loadIR;
            if (loadIR) ld_count++;
        end else begin
            prev_ld = 1'b0;
        end
    end

    task automatic tick();
        @(posedge iclk);
        #2;
    endtask

    task automatic wait_load(input string name, input int max_cycles);
        bit got = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            tick();
            got = loadIR;
        end
        check({name, "_loadIR_seen"}, 32'(got), 32'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},        32'(pc),        32'(0));
        check({tag, "_mem_req"},   32'(mem_req),   32'(0));
        check({tag, "_mem_addr"},  32'(mem_addr),  32'(0));
        check({tag, "_insin"},     32'(insin),     32'(0));
        check({tag, "_loadIR"},    32'(loadIR),    32'(0));
        check({tag, "_ins_valid"}, 32'(ins_valid), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i) ^ 16'hA500;
        mem[12'h000] = 16'h3A05;
        mem[12'h001] = 16'h1111;
        mem[12'h005] = 16'h0555;
        mem[12'h040] = 16'h4040;
        mem[12'h041] = 16'h7777;
        mem[12'h123] = 16'h5A5A;
        mem[12'hFFF] = 16'hBEEF;

        irst_n = 1'b0; run = 1'b0; next = 1'b0; jump = 1'b0; jump_addr = '0;
        tick(); tick();
        check_reset_outputs("reset");

        // First fetch after reset with zero-wait memory
        irst_n = 1'b1; run = 1'b1;
        tick();
        check("first_req",  32'(mem_req),  32'(1));
        check("first_addr", 32'(mem_addr), 32'(0));
        wait_load("first", 4);
        check("first_insin", 32'(insin),     32'h3A05);
        check("first_pc",    32'(pc),        32'h001);
        check("first_valid", 32'(ins_valid), 32'(1));
        tick();
        check("first_ld_pulse", 32'(loadIR),    32'(0));
        check("first_held",     32'(ins_valid), 32'(1));

        // Four-cycle wait: request and address stay stable
        mem_wait = 4; next = 1'b1;
        tick();
        next = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wait_req",  32'(mem_req),  32'(1));
            check("wait_addr", 32'(mem_addr), 32'h001);
            check("wait_nold", 32'(loadIR),   32'(0));
        end
        wait_load("wait", 3);
        check("wait_insin", 32'(insin), 32'h1111);
        check("wait_pc",    32'(pc),    32'h002);

        // Wrap from 0xFFF
        mem_wait = 0; jump = 1'b1; jump_addr = 12'hFFF;
        tick();
        jump = 1'b0;
        check("wrap_addr", 32'(mem_addr), 32'hFFF);
        wait_load("wrap", 4);
        check("wrap_insin", 32'(insin), 32'hBEEF);
        check("wrap_pc",    32'(pc),    32'h000);
        next = 1'b1;
        tick();
        next = 1'b0;
        check("wrap_next_addr", 32'(mem_addr), 32'h000);
        wait_load("wrap_next", 4);
        check("wrap_next_pc", 32'(pc), 32'h001);

        // Jump two cycles before the ack of address 5
        mem_wait = 4; jump = 1'b1; jump_addr = 12'h005;
        tick();
        jump = 1'b0;
        check("flush_addr5", 32'(mem_addr), 32'h005);
        tick(); tick();
        jump = 1'b1; jump_addr = 12'h123;
        tick();
        jump = 1'b0;
        tick();
        mem_wait = 0;
        tick();
        check("flush_drop_ld",    32'(loadIR),   32'(0));
        check("flush_insin_kept", 32'(insin),    32'h3A05);
        check("flush_req",        32'(mem_req),  32'(1));
        check("flush_new_addr",   32'(mem_addr), 32'h123);
        wait_load("flush", 4);
        check("flush_insin", 32'(insin), 32'h5A5A);
        check("flush_pc",    32'(pc),    32'h124);

        // Jump while holding
        jump = 1'b1; jump_addr = 12'h040;
        tick();
        jump = 1'b0;
        check("hold_jump_valid", 32'(ins_valid), 32'(0));
        check("hold_jump_req",   32'(mem_req),   32'(1));
        check("hold_jump_addr",  32'(mem_addr),  32'h040);
        wait_load("hold_jump", 4);
        check("hold_jump_pc", 32'(pc), 32'h041);

        // run dropped mid-fetch: read completes, then unit idles
        next = 1'b1;
        tick();
        next = 1'b0; run = 1'b0;
        wait_load("stop", 4);
        check("stop_insin", 32'(insin), 32'h7777);
        next = 1'b1;
        tick();
        next = 1'b0;
        check("stop_req",   32'(mem_req),   32'(0));
        check("stop_valid", 32'(ins_valid), 32'(0));
        check("stop_pc",    32'(pc),        32'h042);
        tick();
        check("stop_idle_req", 32'(mem_req), 32'(0));

        // Asynchronous reset in the middle of a fetch, then a stray late ack
        mem_wait = 10; run = 1'b1;
        tick();
        check("rst_fetch_addr", 32'(mem_addr), 32'h042);
        tick(); tick();
        irst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        run = 1'b0; mem_en = 1'b0;
        tick();
        irst_n = 1'b1; force_ack = 1'b1;
        tick(); tick();
        check("late_ack_req", 32'(mem_req),   32'(0));
        check("late_ack_ld",  32'(loadIR),    32'(0));
        check("late_ack_pc",  32'(pc),        32'(0));
        check("late_ack_vld", 32'(ins_valid), 32'(0));
        force_ack = 1'b0;
        tick();

        check("total_loadIR_pulses", 32'(ld_count), 32'(7));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
